// File: rtl/filter_pad_sequencer_if.sv
// Pixel-source and filter-side handshake bundle for filter_pad_sequencer.
// master = sequencer side, slave = pixel source / filter side.
interface filter_pad_sequencer_if;
  logic        iPixValid;
  logic [23:0] iPixData;
  logic        oPixReady;
  logic        oValid;
  logic [23:0] oData;
  logic        iFilterDone;
  logic        iFilterValid;

  modport master (
    input  iPixValid, iPixData, iFilterDone, iFilterValid,
    output oPixReady, oValid, oData
  );

  modport slave (
    output iPixValid, iPixData, iFilterDone, iFilterValid,
    input  oPixReady, oValid, oData
  );
endinterface

// File: rtl/filter_pad_sequencer.sv
// Feeds a streaming convolution filter: zero-pads each frame, appends a flush row,
// then keeps issuing zero beats until the filter reports done or a drain timeout.
module filter_pad_sequencer #(
  parameter int WIDTH       = 320,
  parameter int HEIGHT      = 240,
  parameter int KERNEL_SIZE = 3,
  parameter int DRAIN_MAX   = 32
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          iStart,
  filter_pad_sequencer_if.master        bus,
  output logic                          oBusy,
  output logic                          oFrameDone,
  output logic                          oError,
  output logic [31:0]                   oOutCnt
);
  localparam int B          = (KERNEL_SIZE - 1) / 2;
  localparam int ROW_BEATS  = WIDTH + 2 * B;
  localparam int TOTAL_ROWS = HEIGHT + 2 * B + 1;
  localparam int DW         = $clog2(DRAIN_MAX + 1);

  localparam logic [15:0]   PIX_LO        = 16'(B);
  localparam logic [15:0]   PIX_HI        = 16'(B + WIDTH);
  localparam logic [15:0]   COL_LAST      = 16'(ROW_BEATS - 1);
  localparam logic [15:0]   ROW_PAD_LAST  = 16'(B - 1);
  localparam logic [15:0]   ROW_BODY_LAST = 16'(B + HEIGHT - 1);
  localparam logic [15:0]   ROW_TAIL_LAST = 16'(TOTAL_ROWS - 1);
  localparam logic [DW-1:0] DRAIN_LAST    = DW'(DRAIN_MAX - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PAD   = 3'd1;
  localparam logic [2:0] S_BODY  = 3'd2;
  localparam logic [2:0] S_TAIL  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    state;
  logic [15:0]   col;
  logic [15:0]   row;
  logic [DW-1:0] drain_cnt;

  logic pix_col;
  logic in_pix;
  logic beat;
  logic row_end;

  // A beat is issued every cycle except in BODY pixel columns with no pixel
  // offered; those cycles stall the filter rather than inserting a bubble value.
  always_comb begin
    pix_col = (col >= PIX_LO) && (col < PIX_HI);
    in_pix  = (state == S_BODY) && pix_col;
    beat    = 1'b0;
    case (state)
      S_PAD, S_TAIL, S_DRAIN: beat = 1'b1;
      S_BODY:                 beat = !pix_col || bus.iPixValid;
      default:                beat = 1'b0;
    endcase
    row_end = beat && (state != S_DRAIN) && (col == COL_LAST);
  end

  assign bus.oPixReady = in_pix;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      col        <= '0;
      row        <= '0;
      drain_cnt  <= '0;
      bus.oValid <= 1'b0;
      bus.oData  <= '0;
      oBusy      <= 1'b0;
      oFrameDone <= 1'b0;
      oError     <= 1'b0;
      oOutCnt    <= '0;
    end else begin
      bus.oValid <= beat;
      bus.oData  <= (beat && in_pix) ? bus.iPixData : '0;
      oFrameDone <= 1'b0;

      if (oBusy && bus.iFilterValid && (oOutCnt != 32'hFFFF_FFFF))
        oOutCnt <= oOutCnt + 32'd1;

      case (state)
        S_IDLE: begin
          if (iStart) begin
            state   <= S_PAD;
            row     <= '0;
            col     <= '0;
            oOutCnt <= '0;
            oError  <= 1'b0;
            oBusy   <= 1'b1;
          end
        end
        S_PAD, S_BODY, S_TAIL: begin
          if (row_end) begin
            col <= '0;
            row <= row + 16'd1;
            if (state == S_PAD && row == ROW_PAD_LAST)
              state <= S_BODY;
            if (state == S_BODY && row == ROW_BODY_LAST)
              state <= S_TAIL;
            if (state == S_TAIL && row == ROW_TAIL_LAST) begin
              state     <= S_DRAIN;
              row       <= '0;
              drain_cnt <= '0;
            end
          end else if (beat) begin
            col <= col + 16'd1;
          end
        end
        S_DRAIN: begin
          // The terminating cycle still issues its zero beat.
          if (bus.iFilterDone || drain_cnt == DRAIN_LAST) begin
            if (!bus.iFilterDone)
              oError <= 1'b1;
            state      <= S_IDLE;
            oBusy      <= 1'b0;
            oFrameDone <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_filter_pad_sequencer.sv
// Randomized bench for filter_pad_sequencer against a frame-level beat model.
module tb_filter_pad_sequencer;
  localparam int W   = 4;
  localparam int H   = 2;
  localparam int K   = 3;
  localparam int DM  = 32;
  localparam int B   = (K - 1) / 2;
  localparam int RB  = W + 2 * B;
  localparam int TR  = H + 2 * B + 1;
  localparam int PRE = RB * TR;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        iStart = 1'b0;
  logic        oBusy, oFrameDone, oError;
  logic [31:0] oOutCnt;

  filter_pad_sequencer_if bus();

  filter_pad_sequencer #(.WIDTH(W), .HEIGHT(H), .KERNEL_SIZE(K), .DRAIN_MAX(DM)) dut (
    .clk(clk), .reset_n(reset_n), .iStart(iStart), .bus(bus),
    .oBusy(oBusy), .oFrameDone(oFrameDone), .oError(oError), .oOutCnt(oOutCnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [23:0] pix [W*H];
  logic [23:0] got_q [$];
  int          pix_idx;
  int          fv_exp;

  // Frame layout: TR rows of RB beats, pixels raster-ordered inside the body window.
  function automatic bit is_pix(input int idx);
    int r, c;
    if (idx >= PRE) return 1'b0;
    r = idx / RB;
    c = idx % RB;
    return (r >= B) && (r < B + H) && (c >= B) && (c < B + W);
  endfunction

  function automatic logic [23:0] exp_beat(input int idx);
    if (!is_pix(idx)) return 24'd0;
    return pix[(idx / RB - B) * W + (idx % RB - B)];
  endfunction

  // mode: 0 valid held, 1 toggling, 2 random. fv_mode: 0 none, 1 random, 2 first 7 cycles.
  // done_after < 0: filter never reports done. abort_pix >= 0: return once that many pixels taken.
  task automatic run_frame(input int mode, input int done_after, input int abort_pix,
                           input int fv_mode, input bit noise, output bit aborted);
    bit xfer, v, fv, finished;
    aborted  = 1'b0;
    finished = 1'b0;
    got_q.delete();
    pix_idx = 0;
    fv_exp  = 0;
    xfer    = 1'b0;
    for (int i = 0; i < W * H; i++) pix[i] = 24'($urandom);
    iStart           = 1'b1;
    bus.iPixValid    = 1'b0;
    bus.iFilterDone  = 1'b0;
    bus.iFilterValid = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      iStart  = 1'b0;
      pix_idx += int'(xfer);
      if (bus.oValid) got_q.push_back(bus.oData);
      if (cyc == 0) begin
        chk("busy_rise", oBusy, 1);
        chk("first_gap", bus.oValid, 0);
        chk("err_clr", oError, 0);
        chk("cnt_clr", oOutCnt, 0);
      end
      if (cyc == 1) chk("first_beat", bus.oValid, 1);
      if (!bus.oValid && got_q.size() > 0 && got_q.size() < PRE)
        chk("gap_col", is_pix(got_q.size()), 1);
      if (mode == 0 && cyc > 0) chk("contig", bus.oValid, 1);
      chk("pix_ready", bus.oPixReady, is_pix(got_q.size()));
      if (oFrameDone) begin
        finished = 1'b1;
        break;
      end
      if (abort_pix >= 0 && pix_idx == abort_pix) begin
        aborted = 1'b1;
        break;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      bus.iPixValid = v;
      bus.iPixData  = (pix_idx < W * H) ? pix[pix_idx] : 24'd0;
      xfer = v && bus.oPixReady;
      case (fv_mode)
        1:       fv = 1'($urandom_range(0, 1));
        2:       fv = (cyc < 7);
        default: fv = 1'b0;
      endcase
      bus.iFilterValid = fv;
      fv_exp += int'(fv);
      if (done_after >= 0 && got_q.size() >= PRE + done_after)
        bus.iFilterDone = 1'b1;
      else if (noise && got_q.size() < PRE - 2)
        bus.iFilterDone = ($urandom_range(0, 7) == 0);
      else
        bus.iFilterDone = 1'b0;
      if (noise && pix_idx >= 1 && pix_idx < W * H - 1 && $urandom_range(0, 3) == 0)
        iStart = 1'b1;
    end
    if (!finished && !aborted) chk("frame_timeout", 0, 1);
  endtask

  task automatic check_frame(input int exp_drain, input bit exp_err);
    int n;
    chk("beat_count", got_q.size(), PRE + exp_drain);
    n = (got_q.size() < PRE + exp_drain) ? got_q.size() : PRE + exp_drain;
    for (int i = 0; i < n; i++) chk($sformatf("beat%0d", i), got_q[i], exp_beat(i));
    chk("pix_used", pix_idx, W * H);
    chk("error", oError, exp_err);
    chk("outcnt", oOutCnt, fv_exp);
    chk("busy_fall", oBusy, 0);
  endtask

  task automatic idle(input int n, input bit fv, input bit exp_err, input int exp_cnt);
    bus.iFilterDone = 1'b0;
    bus.iPixValid   = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus.iFilterValid = fv;
      @(negedge clk);
      chk("extra_done", oFrameDone, 0);
      chk("idle_valid", bus.oValid, 0);
      chk("idle_busy", oBusy, 0);
      chk("err_hold", oError, exp_err);
      chk("idle_cnt", oOutCnt, exp_cnt);
    end
    bus.iFilterValid = 1'b0;
  endtask

  initial begin
    bit ab;
    bus.iPixValid    = 1'b0;
    bus.iPixData     = '0;
    bus.iFilterDone  = 1'b0;
    bus.iFilterValid = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_data", bus.oData, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_done", oFrameDone, 0);
    chk("rst_err", oError, 0);
    chk("rst_cnt", oOutCnt, 0);
    chk("rst_ready", bus.oPixReady, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // held valid, done 5 beats into DRAIN
    run_frame(0, 5, -1, 0, 1'b0, ab);
    check_frame(6, 1'b0);
    idle(3, 1'b0, 1'b0, 0);

    // toggling valid gives the same beat sequence with gaps only in pixel columns
    run_frame(1, 5, -1, 0, 1'b0, ab);
    check_frame(6, 1'b0);
    idle(2, 1'b0, 1'b0, 0);

    // drain timeout with stray start/done pulses; error is sticky while idle
    run_frame(2, -1, -1, 1, 1'b1, ab);
    check_frame(DM, 1'b1);
    idle(4, 1'b0, 1'b1, fv_exp);

    // start inside the frame-done cycle chains straight into the next frame
    run_frame(2, 5, -1, 1, 1'b1, ab);
    check_frame(6, 1'b0);
    run_frame(0, 2, -1, 1, 1'b0, ab);
    check_frame(3, 1'b0);
    idle(2, 1'b0, 1'b0, fv_exp);

    // 7 filter-valid beats while busy, 3 while idle
    run_frame(1, 5, -1, 2, 1'b0, ab);
    check_frame(6, 1'b0);
    idle(3, 1'b1, 1'b0, 7);
    idle(1, 1'b0, 1'b0, 7);

    // reset mid-body aborts without a completion pulse
    run_frame(0, 5, 3, 0, 1'b0, ab);
    chk("aborted", ab, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_valid", bus.oValid, 0);
    chk("abort_data", bus.oData, 0);
    chk("abort_busy", oBusy, 0);
    chk("abort_done", oFrameDone, 0);
    chk("abort_ready", bus.oPixReady, 0);
    chk("abort_cnt", oOutCnt, 0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", oFrameDone, 0);
      chk("abort_novalid", bus.oValid, 0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(2, 5, -1, 1, 1'b0, ab);
    check_frame(6, 1'b0);
    idle(2, 1'b0, 1'b0, fv_exp);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
